// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the five-stage MCU core.
// Produces the IF/ID/EXE stall enables, branch flush and bubble controls,
// operand forwarding selects into ID, a halt state for illegal instructions
// and a saturating count of stall/freeze cycles.
module hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [1:0]  LOAD_SRC = 2'b01
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       rs1_idx_d_i,
  input  logic [4:0]       rs2_idx_d_i,
  input  logic             rs1_used_d_i,
  input  logic             rs2_used_d_i,
  input  logic             taken_d_i,
  input  logic [4:0]       rd_idx_e_i,
  input  logic             reg_write_en_e_i,
  input  logic [4:0]       rd_idx_m_i,
  input  logic             reg_write_en_m_i,
  input  logic [1:0]       result_src_m_i,
  input  logic [4:0]       rd_idx_w_i,
  input  logic             reg_write_en_w_i,
  input  logic             dmem_busy_m_i,
  input  logic             instr_illegal_e_i,
  output logic             enable_f_o,
  output logic             enable_d_o,
  output logic             enable_em_o,
  output logic             flush_d_o,
  output logic             bubble_e_o,
  output logic             taken_h_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic             rs1_depended_h_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hit_e1, hit_e2, hit_m1, hit_m2, hit_w1, hit_w2;
  logic load_m, dstall, halted, freeze, counting;
  logic [1:0] fwd1_raw, fwd2_raw;

  // A source register matches a producer only if it is read, is not x0,
  // and the producer actually writes that register.
  function automatic logic reg_hit(input logic       used,
                                   input logic [4:0] rs,
                                   input logic       we,
                                   input logic [4:0] rd);
    return used && (rs != 5'd0) && we && (rd == rs);
  endfunction

  // Producer/consumer matching against every downstream stage.
  always_comb begin
    hit_e1 = reg_hit(rs1_used_d_i, rs1_idx_d_i, reg_write_en_e_i, rd_idx_e_i);
    hit_e2 = reg_hit(rs2_used_d_i, rs2_idx_d_i, reg_write_en_e_i, rd_idx_e_i);
    hit_m1 = reg_hit(rs1_used_d_i, rs1_idx_d_i, reg_write_en_m_i, rd_idx_m_i);
    hit_m2 = reg_hit(rs2_used_d_i, rs2_idx_d_i, reg_write_en_m_i, rd_idx_m_i);
    hit_w1 = reg_hit(rs1_used_d_i, rs1_idx_d_i, reg_write_en_w_i, rd_idx_w_i);
    hit_w2 = reg_hit(rs2_used_d_i, rs2_idx_d_i, reg_write_en_w_i, rd_idx_w_i);
  end

  // Hazard classification and raw forwarding choice per operand.
  // Operands are consumed in ID, so an EXE producer always stalls, and a
  // load still in MEM has no data yet and stalls one more cycle.
  always_comb begin
    load_m   = (result_src_m_i == LOAD_SRC);
    dstall   = hit_e1 || hit_e2 || ((hit_m1 || hit_m2) && load_m);
    halted   = (state_q == ST_HALT);
    freeze   = !halted && dmem_busy_m_i;
    counting = !halted && (dmem_busy_m_i || dstall);

    fwd1_raw = FWD_RF;
    if (hit_m1 && !load_m) begin
      fwd1_raw = FWD_MEM;
    end else if (hit_w1) begin
      fwd1_raw = FWD_WB;
    end

    fwd2_raw = FWD_RF;
    if (hit_m2 && !load_m) begin
      fwd2_raw = FWD_MEM;
    end else if (hit_w2) begin
      fwd2_raw = FWD_WB;
    end
  end

  // Next state: HALT is entered only once memory is idle and is left only
  // through reset; the stall counter saturates instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (resetn) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      if ((state_q == ST_RUN) && instr_illegal_e_i && !dmem_busy_m_i) begin
        state_d = ST_HALT;
      end
      if (counting && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State and counter registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline controls in priority order: reset, halt, freeze, data stall,
  // normal flow. Forwarding is forced to the regfile whenever the ID-stage
  // operands are not being consumed this cycle.
  always_comb begin
    enable_f_o    = 1'b1;
    enable_d_o    = 1'b1;
    enable_em_o   = 1'b1;
    flush_d_o     = 1'b0;
    bubble_e_o    = 1'b0;
    taken_h_o     = 1'b0;
    fwd_rs1_sel_o = FWD_RF;
    fwd_rs2_sel_o = FWD_RF;
    halted_o      = 1'b0;
    if (resetn) begin
      flush_d_o  = 1'b1;
      bubble_e_o = 1'b1;
    end else if (halted) begin
      enable_f_o  = 1'b0;
      enable_d_o  = 1'b0;
      enable_em_o = 1'b0;
      halted_o    = 1'b1;
    end else if (freeze) begin
      enable_f_o  = 1'b0;
      enable_d_o  = 1'b0;
      enable_em_o = 1'b0;
    end else if (dstall) begin
      // Branch redirect is held back until its operands are valid.
      enable_f_o = 1'b0;
      bubble_e_o = 1'b1;
    end else begin
      taken_h_o     = taken_d_i;
      flush_d_o     = taken_d_i;
      fwd_rs1_sel_o = fwd1_raw;
      fwd_rs2_sel_o = fwd2_raw;
    end
  end

  assign rs1_depended_h_o = (fwd_rs1_sel_o != FWD_RF);
  assign stall_cnt_o      = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the five-stage MCU core.
- Drives the IF/ID/EXE stall enables and the branch-flush/bubble controls, and selects operand forwarding into ID.
- Masks branch redirects while ID operands are stale.
- Freezes the pipeline on data-memory wait and halts it on an illegal instruction reaching EXE.
- Replaces the constant top-level `enable` and `rs1_depended_h_o` signals.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- LOAD_SRC, 2'b01, result_src encoding that marks a load (data from memory).

Ports:
- clk  input  1  core clock.
- resetn  input  1  synchronous reset, active-high (1 = reset) in this block.
- rs1_idx_d_i  input  5  ID-stage rs1 index.
- rs2_idx_d_i  input  5  ID-stage rs2 index.
- rs1_used_d_i  input  1  ID instruction reads rs1.
- rs2_used_d_i  input  1  ID instruction reads rs2.
- taken_d_i  input  1  raw branch/jump taken from ID.
- rd_idx_e_i  input  5  EXE-stage destination register.
- reg_write_en_e_i  input  1  EXE-stage writes rd.
- rd_idx_m_i  input  5  MEM-stage destination register.
- reg_write_en_m_i  input  1  MEM-stage writes rd.
- result_src_m_i  input  2  MEM-stage result source.
- rd_idx_w_i  input  5  WB-stage destination register.
- reg_write_en_w_i  input  1  WB-stage writes rd.
- dmem_busy_m_i  input  1  data memory not ready this cycle.
- instr_illegal_e_i  input  1  illegal instruction in EXE.
- enable_f_o  output  1  PC / IF-ID register enable.
- enable_d_o  output  1  ID-EXE register enable.
- enable_em_o  output  1  EXE-MEM and MEM-WB register enable.
- flush_d_o  output  1  invalidate the IF-ID register (NOP next cycle).
- bubble_e_o  output  1  load a NOP into ID-EXE.
- taken_h_o  output  1  gated taken used for the IF redirect.
- fwd_rs1_sel_o  output  2  00 regfile, 01 MEM result, 10 WB data.
- fwd_rs2_sel_o  output  2  same encoding as fwd_rs1_sel_o.
- rs1_depended_h_o  output  1  fwd_rs1_sel_o != 00.
- halted_o  output  1  core halted.
- stall_cnt_o  output  CNT_W  total stall/freeze cycles.

Behaviour:
- Match rules:
  - hitX(rs) = used && rs != 0 && reg_write_en_X && rd_idx_X == rs, for X in {e, m, w}.
  - x0 never matches.
- Data stall: dstall = hitE(rs1|rs2) || (hitM(rs1|rs2) && result_src_m_i == LOAD_SRC). Operands are read and compared in ID, so any EXE producer stalls; a load in MEM stalls one extra cycle.
- Forwarding, per operand, highest first:
  - MEM non-load hit -> 01.
  - else WB hit -> 10.
  - else 00.
  - Combinational. Forced to 00 during dstall, freeze and HALT.
- FSM states: RUN, HALT. Reset -> RUN.
  - RUN -> HALT when instr_illegal_e_i=1 and dmem_busy_m_i=0.
  - HALT is exited only by reset.
- Output priority, highest first:
  1. resetn = 1:
     - enables 1, flush 1, bubble 1, taken_h 0, fwd 00, halted 0.
     - stall_cnt cleared to 0 at the edge.
  2. HALT: all enables 0, flush 0, bubble 0, taken_h 0, halted_o 1. Counter holds.
  3. Freeze (dmem_busy_m_i = 1, RUN): all enables 0, bubble 0, flush 0, taken_h 0. Counter +1.
  4. dstall:
     - enable_f 0, enable_d 1, bubble_e 1, enable_em 1, flush 0.
     - taken_h 0 (redirect suppressed; the branch is re-evaluated when its operands are valid).
     - Counter +1.
  5. Otherwise:
     - all enables 1, bubble 0.
     - taken_h_o = taken_d_i.
     - flush_d_o = taken_d_i (kills the wrong-path fetch, 1-cycle branch penalty).
- Simultaneous events:
  - illegal with busy: the freeze wins; HALT is entered once busy drops, and the transition happens on that cycle's edge.
  - illegal entering HALT: outputs for that cycle still follow rules 3–5. Illegal marks the cause, with no retire guarantee.
- Counter saturates at all-ones and never wraps. Registered; updates at the edge following the counted cycle.
- Reset asserted mid-stall or while HALTed: RUN next cycle, counter 0.
- Latency: all controls except state and counter are combinational from the inputs within the cycle.

Test Plan:
- Reset: resetn=1 for 2 cycles -> halted_o=0, stall_cnt_o=0, flush_d_o=1, enables 1; after release with no hazards -> flush 0, bubble 0, fwd 00.
- ALU dependency: EXE writes x5, ID reads rs1=x5 -> 1 cycle with enable_f_o=0 and bubble_e_o=1. Next cycle fwd_rs1_sel_o=01 and rs1_depended_h_o=1. stall_cnt_o=1.
- Load-use: load to x7 in EXE, ID reads rs2=x7 -> 2 stall cycles (EXE, then MEM-load), then fwd_rs2_sel_o=10; stall_cnt_o=2. Same case with rd=x0 -> no stall, fwd 00.
- Branch: taken_d_i=1 with no hazard -> taken_h_o=1, flush_d_o=1. taken_d_i=1 during dstall -> taken_h_o=0, flush_d_o=0.
- Memory wait: dmem_busy_m_i=1 for 3 cycles -> all enables 0 for exactly 3 cycles, stall_cnt_o +3. Assert instr_illegal_e_i in the 2nd busy cycle and hold it -> HALT entered at the edge after busy drops; halted_o=1 and all enables 0 until reset.
- Saturation: run with CNT_W=4 and 20 stall cycles -> stall_cnt_o=15 and it stays at 15.
